fir_axil_cfg_master: RTL and testbench
======================================

# fir_axil_cfg_master

AXI-Lite initiator that programs and launches the FIR engine over its AXI-Lite configuration port. On a `go` pulse it writes the data length, writes all tap coefficients, reads each tap back for verification, writes ap_start, then polls ap_ctrl until done. It sits between the host/testbench control logic and the FIR's `aw*/w*/ar*/r*` slave channels. There is no B channel; a write completes when both the AW and W handshakes have occurred.

## Interface
- `pADDR_WIDTH`, 12, AXI-Lite address width
- `pDATA_WIDTH`, 32, AXI-Lite data width
- `Tape_Num`, 11, number of taps written and verified
- `POLL_GAP`, 4, idle cycles between ap_ctrl poll reads
- `POLL_MAX`, 1024, poll reads before timeout

Ports:
- `axis_clk` in 1: the only clock.
- `axis_rst_n` in 1: asynchronous, active-low reset.
- `go` in 1: start pulse. Ignored while `busy`.
- `len` in pDATA_WIDTH: value written to DATA_LENGTH (0x10). Sampled at `go`.
- `coef` in Tape_Num*pDATA_WIDTH: tap i occupies bits [32i+31:32i]. Sampled at `go`.
- `busy` out 1: sequence in progress.
- `done` out 1: one-cycle pulse on successful completion.
- `err` out 1: sticky until next accepted `go`.
- `err_code` out 2: 0 none, 1 tap readback mismatch, 2 poll timeout.
- `err_idx` out 4: failing tap index when `err_code`=1.
- `awvalid` out 1, `awready` in 1, `awaddr` out pADDR_WIDTH
- `wvalid` out 1, `wready` in 1, `wdata` out pDATA_WIDTH
- `arvalid` out 1, `arready` in 1, `araddr` out pADDR_WIDTH
- `rvalid` in 1, `rready` out 1, `rdata` in pDATA_WIDTH

## Operation
- Address map:
  - ap_ctrl 0x00: bit0 start, bit1 done, bit2 idle.
  - DATA_LENGTH 0x10.
  - Taps at 0x20+4·i, for i=0..Tape_Num-1 (0x20..0x48 for 11 taps).
- Top FSM: IDLE → WR_LEN → WR_TAP → RD_TAP → WR_START → POLL_RD → POLL_WAIT → (POLL_RD | FIN | FAIL).
- IDLE: on `go`, latch `len` and `coef`, clear `err`/`err_code`/`err_idx`, set `busy`, move to WR_LEN.
- WR_LEN: write `len` to 0x10.
- WR_TAP: write coef[i] to 0x20+4i for i=0..Tape_Num-1, one transaction per tap, in ascending order.
- RD_TAP: read 0x20+4i for i ascending. If `rdata`≠coef[i]: go to FAIL with code 1 and `err_idx`=i, and issue no further transactions.
- WR_START: write 0x0000_0001 to 0x00.
- POLL_RD: read 0x00 and increment the poll counter.
  - rdata[1]=1 → FIN.
  - Otherwise, if the counter = POLL_MAX → FAIL with code 2.
  - Otherwise → POLL_WAIT for POLL_GAP cycles, then POLL_RD.
- FIN: pulse `done`, clear `busy`, return to IDLE.
- FAIL: set `err`, clear `busy`, return to IDLE.
- Tap index counter width: $clog2(Tape_Num). The poll counter saturates and never wraps.

## Timing
- Reset value of all outputs: 0. FSM resets to IDLE; counters reset to 0.
- Write transaction:
  - `awvalid` and `wvalid` assert in the same cycle, with `awaddr`/`wdata` already stable.
  - Each valid deasserts the cycle after its own handshake (valid&ready), independently of the other.
  - The transaction completes in the cycle after the later handshake.
  - Address and data stay stable while their valid is high.
- Read transaction:
  - `arvalid` is held with `araddr` stable until `arready`.
  - `rready` asserts the cycle after the AR handshake and stays high until `rvalid`.
  - `rdata` is captured on the rvalid&rready cycle.
- Only one transaction is outstanding at a time. `arvalid` and `awvalid` are never high together.
- Best-case latency with ready slaves: 2 cycles per write, 3 per read, plus 1 cycle per FSM state change.
- `go` coincident with FIN or FAIL is ignored.
- Reset asserted mid-transaction clears all valids/readies immediately (asynchronously) and discards the sequence. No `done` or `err` is produced.

## Structure
- Package `fir_cfg_pkg` holds:
  - address constants: AP_CTRL, DATA_LENGTH, COEF_BASE;
  - ap_ctrl bit positions;
  - the top-FSM state enum;
  - the err_code enum.
- Sub-module `axil_xact_engine` carries the single-transaction AW/W/AR/R handshaking.
  - Command side: `req`, `is_wr`, `addr`, `wdata` inputs; `ack` and `rdata` outputs.
  - The top FSM only sequences addresses, data and compares.

## Test plan
- Always-ready slave model; `go` with len=600 and coef={0,-10,-9,23,56,63,56,23,-9,-10,0}:
  - write order is 0x10, then 0x20..0x48, then 0x00=1;
  - 11 reads of 0x20..0x48;
  - slave returns done on the 3rd poll → `done` pulses once, `err`=0.
- Slave corrupts the readback of tap 5 → `err`=1, `err_code`=1, `err_idx`=5, and no write to 0x00 occurs.
- Slave never sets ap_ctrl bit1 with POLL_MAX=8 → exactly 8 reads of 0x00 spaced by POLL_GAP, then `err_code`=2.
- Random backpressure: awready lags wready by 3 cycles, and vice versa → `awaddr`/`wdata` stay stable, each valid drops independently, and the result matches the first scenario.
- `axis_rst_n` pulsed low during a WR_TAP transaction:
  - all outputs are 0 immediately;
  - after release, a new `go` runs the full sequence from 0x10.

Source files
------------

// File: rtl/fir_cfg_pkg.sv
// rtl/fir_cfg_pkg.sv - shared address map, ap_ctrl bits and state/error enums for the FIR config master
package fir_cfg_pkg;

    localparam logic [11:0] AP_CTRL     = 12'h000;
    localparam logic [11:0] DATA_LENGTH = 12'h010;
    localparam logic [11:0] COEF_BASE   = 12'h020;

    localparam int AP_START_BIT = 0;
    localparam int AP_DONE_BIT  = 1;
    localparam int AP_IDLE_BIT  = 2;

    typedef enum logic [3:0] {
        S_IDLE,
        S_WR_LEN,
        S_WR_TAP,
        S_RD_TAP,
        S_WR_START,
        S_POLL_RD,
        S_POLL_WAIT,
        S_FIN,
        S_FAIL
    } top_state_e;

    typedef enum logic [1:0] {
        ERR_NONE = 2'd0,
        ERR_TAP  = 2'd1,
        ERR_POLL = 2'd2
    } err_code_e;

    typedef enum logic [2:0] {
        X_IDLE,
        X_WR,
        X_RD_AR,
        X_RD_R,
        X_ACK
    } xact_state_e;

endpackage

// File: rtl/axil_xact_engine.sv
// rtl/axil_xact_engine.sv - single outstanding AXI-Lite write (AW+W, no B) or read (AR+R) per command
module axil_xact_engine
    import fir_cfg_pkg::*;
#(
    parameter int AW = 12,
    parameter int DW = 32
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          req_i,
    input  logic          is_wr_i,
    input  logic [AW-1:0] addr_i,
    input  logic [DW-1:0] wdata_i,
    output logic          ack_o,
    output logic [DW-1:0] rdata_o,
    output logic          awvalid_o,
    input  logic          awready_i,
    output logic [AW-1:0] awaddr_o,
    output logic          wvalid_o,
    input  logic          wready_i,
    output logic [DW-1:0] wdata_o,
    output logic          arvalid_o,
    input  logic          arready_i,
    output logic [AW-1:0] araddr_o,
    input  logic          rvalid_i,
    output logic          rready_o,
    input  logic [DW-1:0] rdata_i
);

    xact_state_e   state_q, state_d;
    logic          awvalid_q, awvalid_d, wvalid_q, wvalid_d;
    logic          arvalid_q, arvalid_d, rready_q, rready_d;
    logic [AW-1:0] awaddr_q, awaddr_d, araddr_q, araddr_d;
    logic [DW-1:0] wdata_q, wdata_d, rdata_q, rdata_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= X_IDLE;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            awaddr_q  <= '0;
            araddr_q  <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            arvalid_q <= arvalid_d;
            rready_q  <= rready_d;
            awaddr_q  <= awaddr_d;
            araddr_q  <= araddr_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        arvalid_d = arvalid_q;
        rready_d  = rready_q;
        awaddr_d  = awaddr_q;
        araddr_d  = araddr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        case (state_q)
            X_IDLE: begin
                if (req_i && is_wr_i) begin
                    awvalid_d = 1'b1;
                    wvalid_d  = 1'b1;
                    awaddr_d  = addr_i;
                    wdata_d   = wdata_i;
                    state_d   = X_WR;
                end else if (req_i) begin
                    arvalid_d = 1'b1;
                    araddr_d  = addr_i;
                    state_d   = X_RD_AR;
                end
            end
            // AW and W retire independently; the write is done once both have.
            X_WR: begin
                if (awready_i) awvalid_d = 1'b0;
                if (wready_i)  wvalid_d  = 1'b0;
                if (!awvalid_d && !wvalid_d) state_d = X_ACK;
            end
            X_RD_AR: begin
                if (arready_i) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = X_RD_R;
                end
            end
            X_RD_R: begin
                if (rvalid_i) begin
                    rready_d = 1'b0;
                    rdata_d  = rdata_i;
                    state_d  = X_ACK;
                end
            end
            // The requester still holds req during the ack cycle, so never launch from here.
            X_ACK:   state_d = X_IDLE;
            default: state_d = X_IDLE;
        endcase
    end

    assign ack_o     = (state_q == X_ACK);
    assign rdata_o   = rdata_q;
    assign awvalid_o = awvalid_q;
    assign awaddr_o  = awaddr_q;
    assign wvalid_o  = wvalid_q;
    assign wdata_o   = wdata_q;
    assign arvalid_o = arvalid_q;
    assign araddr_o  = araddr_q;
    assign rready_o  = rready_q;

endmodule

// File: rtl/fir_axil_cfg_master.sv
// rtl/fir_axil_cfg_master.sv - programs length and taps, verifies taps, starts the FIR and polls for done
module fir_axil_cfg_master
    import fir_cfg_pkg::*;
#(
    parameter int pADDR_WIDTH = 12,
    parameter int pDATA_WIDTH = 32,
    parameter int Tape_Num    = 11,
    parameter int POLL_GAP    = 4,
    parameter int POLL_MAX    = 1024
) (
    input  logic                            axis_clk,
    input  logic                            axis_rst_n,
    input  logic                            go,
    input  logic [pDATA_WIDTH-1:0]          len,
    input  logic [Tape_Num*pDATA_WIDTH-1:0] coef,
    output logic                            busy,
    output logic                            done,
    output logic                            err,
    output logic [1:0]                      err_code,
    output logic [3:0]                      err_idx,
    output logic                            awvalid,
    input  logic                            awready,
    output logic [pADDR_WIDTH-1:0]          awaddr,
    output logic                            wvalid,
    input  logic                            wready,
    output logic [pDATA_WIDTH-1:0]          wdata,
    output logic                            arvalid,
    input  logic                            arready,
    output logic [pADDR_WIDTH-1:0]          araddr,
    input  logic                            rvalid,
    output logic                            rready,
    input  logic [pDATA_WIDTH-1:0]          rdata
);

    localparam int IDX_W  = $clog2(Tape_Num);
    localparam int PCNT_W = $clog2(POLL_MAX + 1);
    localparam int GAP_W  = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;

    top_state_e                      state_q, state_d;
    logic [pDATA_WIDTH-1:0]          len_q, len_d;
    logic [Tape_Num*pDATA_WIDTH-1:0] coef_q, coef_d;
    logic [IDX_W-1:0]                idx_q, idx_d;
    logic [PCNT_W-1:0]               poll_q, poll_d, poll_inc;
    logic [GAP_W-1:0]                gap_q, gap_d;
    logic                            err_q, err_d;
    err_code_e                       code_q, code_d;
    logic [3:0]                      eidx_q, eidx_d;

    logic                   req, is_wr, ack, last_tap;
    logic [pADDR_WIDTH-1:0] req_addr, tap_addr;
    logic [pDATA_WIDTH-1:0] req_wdata, rsp_rdata, cur_coef;

    assign last_tap = (idx_q == IDX_W'(Tape_Num - 1));
    assign tap_addr = pADDR_WIDTH'(COEF_BASE) + (pADDR_WIDTH'(idx_q) << 2);
    assign cur_coef = coef_q[int'(idx_q) * pDATA_WIDTH +: pDATA_WIDTH];
    assign poll_inc = (poll_q == PCNT_W'(POLL_MAX)) ? poll_q : poll_q + PCNT_W'(1);

    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            state_q <= S_IDLE;
            len_q   <= '0;
            coef_q  <= '0;
            idx_q   <= '0;
            poll_q  <= '0;
            gap_q   <= '0;
            err_q   <= 1'b0;
            code_q  <= ERR_NONE;
            eidx_q  <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            coef_q  <= coef_d;
            idx_q   <= idx_d;
            poll_q  <= poll_d;
            gap_q   <= gap_d;
            err_q   <= err_d;
            code_q  <= code_d;
            eidx_q  <= eidx_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        coef_d    = coef_q;
        idx_d     = idx_q;
        poll_d    = poll_q;
        gap_d     = gap_q;
        err_d     = err_q;
        code_d    = code_q;
        eidx_d    = eidx_q;
        req       = 1'b0;
        is_wr     = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        case (state_q)
            S_IDLE: begin
                if (go) begin
                    len_d   = len;
                    coef_d  = coef;
                    err_d   = 1'b0;
                    code_d  = ERR_NONE;
                    eidx_d  = '0;
                    idx_d   = '0;
                    poll_d  = '0;
                    state_d = S_WR_LEN;
                end
            end
            S_WR_LEN: begin
                req       = 1'b1;
                is_wr     = 1'b1;
                req_addr  = pADDR_WIDTH'(DATA_LENGTH);
                req_wdata = len_q;
                if (ack) begin
                    idx_d   = '0;
                    state_d = S_WR_TAP;
                end
            end
            S_WR_TAP: begin
                req       = 1'b1;
                is_wr     = 1'b1;
                req_addr  = tap_addr;
                req_wdata = cur_coef;
                if (ack) begin
                    idx_d   = last_tap ? '0 : idx_q + IDX_W'(1);
                    state_d = last_tap ? S_RD_TAP : S_WR_TAP;
                end
            end
            S_RD_TAP: begin
                req      = 1'b1;
                req_addr = tap_addr;
                if (ack) begin
                    if (rsp_rdata != cur_coef) begin
                        err_d   = 1'b1;
                        code_d  = ERR_TAP;
                        eidx_d  = 4'(idx_q);
                        state_d = S_FAIL;
                    end else if (last_tap) begin
                        state_d = S_WR_START;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            S_WR_START: begin
                req       = 1'b1;
                is_wr     = 1'b1;
                req_addr  = pADDR_WIDTH'(AP_CTRL);
                req_wdata = pDATA_WIDTH'(1) << AP_START_BIT;
                if (ack) begin
                    poll_d  = '0;
                    state_d = S_POLL_RD;
                end
            end
            S_POLL_RD: begin
                req      = 1'b1;
                req_addr = pADDR_WIDTH'(AP_CTRL);
                if (ack) begin
                    poll_d = poll_inc;
                    gap_d  = '0;
                    if (rsp_rdata[AP_DONE_BIT]) begin
                        state_d = S_FIN;
                    end else if (poll_inc == PCNT_W'(POLL_MAX)) begin
                        err_d   = 1'b1;
                        code_d  = ERR_POLL;
                        state_d = S_FAIL;
                    end else begin
                        state_d = S_POLL_WAIT;
                    end
                end
            end
            S_POLL_WAIT: begin
                if (gap_q == GAP_W'(POLL_GAP - 1)) state_d = S_POLL_RD;
                else                               gap_d   = gap_q + GAP_W'(1);
            end
            S_FIN:   state_d = S_IDLE;
            S_FAIL:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign busy     = (state_q != S_IDLE) && (state_q != S_FIN) && (state_q != S_FAIL);
    assign done     = (state_q == S_FIN);
    assign err      = err_q;
    assign err_code = code_q;
    assign err_idx  = eidx_q;

    axil_xact_engine #(
        .AW (pADDR_WIDTH),
        .DW (pDATA_WIDTH)
    ) u_xact (
        .clk_i     (axis_clk),
        .rst_ni    (axis_rst_n),
        .req_i     (req),
        .is_wr_i   (is_wr),
        .addr_i    (req_addr),
        .wdata_i   (req_wdata),
        .ack_o     (ack),
        .rdata_o   (rsp_rdata),
        .awvalid_o (awvalid),
        .awready_i (awready),
        .awaddr_o  (awaddr),
        .wvalid_o  (wvalid),
        .wready_i  (wready),
        .wdata_o   (wdata),
        .arvalid_o (arvalid),
        .arready_i (arready),
        .araddr_o  (araddr),
        .rvalid_i  (rvalid),
        .rready_o  (rready),
        .rdata_i   (rdata)
    );

endmodule

// File: tb/tb_fir_axil_cfg_master.sv
// tb/tb_fir_axil_cfg_master.sv - table-driven bench for fir_axil_cfg_master against a behavioural AXI-Lite FIR slave
module tb_fir_axil_cfg_master;

    localparam int AW = 12;
    localparam int DW = 32;
    localparam int NT = 11;
    localparam int GAP = 4;
    localparam int PMAX = 8;
    // AR-to-AR distance between polls: 3-cycle read + 1 state change + POLL_GAP idle cycles.
    localparam int POLL_SPACING = 8;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           go = 1'b0;
    logic [DW-1:0]  len = '0;
    logic [NT*DW-1:0] coef = '0;
    logic           busy, done, err;
    logic [1:0]     err_code;
    logic [3:0]     err_idx;
    logic           awvalid, wvalid, arvalid, rready;
    logic           awready = 1'b0, wready = 1'b0, arready = 1'b1, rvalid = 1'b0;
    logic [AW-1:0]  awaddr, araddr;
    logic [DW-1:0]  wdata, rdata = '0;
    logic [68:0]    outs;

    always #5 clk = ~clk;

    fir_axil_cfg_master #(
        .pADDR_WIDTH (AW),
        .pDATA_WIDTH (DW),
        .Tape_Num    (NT),
        .POLL_GAP    (GAP),
        .POLL_MAX    (PMAX)
    ) dut (
        .axis_clk   (clk),
        .axis_rst_n (rst_n),
        .go         (go),
        .len        (len),
        .coef       (coef),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .err_code   (err_code),
        .err_idx    (err_idx),
        .awvalid    (awvalid),
        .awready    (awready),
        .awaddr     (awaddr),
        .wvalid     (wvalid),
        .wready     (wready),
        .wdata      (wdata),
        .arvalid    (arvalid),
        .arready    (arready),
        .araddr     (araddr),
        .rvalid     (rvalid),
        .rready     (rready),
        .rdata      (rdata)
    );

    assign outs = {busy, done, err, err_code, err_idx, awvalid, wvalid, arvalid, rready,
                   awaddr, wdata, araddr};

    typedef struct {
        int   aw_dly;
        int   w_dly;
        int   corrupt;
        int   done_poll;
        int   e_done;
        logic e_err;
        int   e_code;
        int   e_idx;
        int   e_wr;
        int   e_rd;
        int   e_polls;
    } vec_t;

    vec_t vecs [5];
    vec_t cfg;
    int   taps [NT] = '{0, -10, -9, 23, 56, 63, 56, 23, -9, -10, 0};
    logic [NT*DW-1:0] coef_vec;

    int n_vec = 0;
    int n_bad = 0;

    // slave bookkeeping (posedge process)
    logic [AW-1:0] wr_addr_log [$];
    logic [DW-1:0] wr_data_log [$];
    logic [AW-1:0] rd_log [$];
    int            poll_times [$];
    logic [DW-1:0] mem [NT];
    logic [AW-1:0] cap_aw;
    logic [DW-1:0] cap_w, rd_val;
    logic          got_aw = 1'b0, got_w = 1'b0, rd_pend = 1'b0;
    int            aw_hs_n = 0, w_hs_n = 0, ar_hs_n = 0, cyc = 0, ti;

    // monitor / ready generation (negedge process)
    int            aw_wait = 0, w_wait = 0, done_cnt = 0, proto_err = 0;
    int            aw_seen = 0, w_seen = 0, ar_seen = 0;
    logic          aw_hold = 1'b0, w_hold = 1'b0, ar_hold = 1'b0;
    logic [AW-1:0] aw_hold_a, ar_hold_a;
    logic [DW-1:0] w_hold_d;

    // bases written by the stimulus process only
    int wr_base, rd_base, poll_base, done_base, proto_base;

    always @(posedge clk) begin
        cyc++;
        if (!rst_n) begin
            got_aw  = 1'b0;
            got_w   = 1'b0;
            rd_pend = 1'b0;
        end else begin
            if (awvalid && awready) begin cap_aw = awaddr; got_aw = 1'b1; aw_hs_n++; end
            if (wvalid && wready)   begin cap_w  = wdata;  got_w  = 1'b1; w_hs_n++;  end
            if (got_aw && got_w) begin
                wr_addr_log.push_back(cap_aw);
                wr_data_log.push_back(cap_w);
                if (cap_aw >= 12'h020 && cap_aw <= 12'h048) mem[(int'(cap_aw) - 32) >> 2] = cap_w;
                got_aw = 1'b0;
                got_w  = 1'b0;
            end
            if (rvalid && rready) rd_pend = 1'b0;
            if (arvalid && arready) begin
                rd_log.push_back(araddr);
                ar_hs_n++;
                rd_pend = 1'b1;
                if (araddr == 12'h000) begin
                    poll_times.push_back(cyc);
                    rd_val = (cfg.done_poll != 0 && poll_times.size() - poll_base >= cfg.done_poll)
                             ? 32'h6 : 32'h0;
                end else begin
                    ti = (int'(araddr) - 32) >> 2;
                    rd_val = (ti >= 0 && ti < NT) ? mem[ti] : 32'hBAD0_BAD0;
                    if (ti == cfg.corrupt) rd_val = rd_val ^ 32'h1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            awready = 1'b0;
            wready  = 1'b0;
            rvalid  = 1'b0;
            aw_wait = 0;
            w_wait  = 0;
            aw_hold = 1'b0;
            w_hold  = 1'b0;
            ar_hold = 1'b0;
            aw_seen = aw_hs_n;
            w_seen  = w_hs_n;
            ar_seen = ar_hs_n;
        end else begin
            if (done === 1'b1) done_cnt++;
            if (awvalid && arvalid) proto_err++;
            if (aw_hs_n != aw_seen) begin
                if (awvalid) proto_err++;
                aw_seen = aw_hs_n; aw_hold = 1'b0;
            end else if (awvalid) begin
                if (aw_hold && awaddr !== aw_hold_a) proto_err++;
                aw_hold = 1'b1; aw_hold_a = awaddr;
            end else aw_hold = 1'b0;
            if (w_hs_n != w_seen) begin
                if (wvalid) proto_err++;
                w_seen = w_hs_n; w_hold = 1'b0;
            end else if (wvalid) begin
                if (w_hold && wdata !== w_hold_d) proto_err++;
                w_hold = 1'b1; w_hold_d = wdata;
            end else w_hold = 1'b0;
            if (ar_hs_n != ar_seen) begin
                if (arvalid) proto_err++;
                ar_seen = ar_hs_n; ar_hold = 1'b0;
            end else if (arvalid) begin
                if (ar_hold && araddr !== ar_hold_a) proto_err++;
                ar_hold = 1'b1; ar_hold_a = araddr;
            end else ar_hold = 1'b0;
            awready = awvalid && (aw_wait >= cfg.aw_dly);
            aw_wait = awvalid ? aw_wait + 1 : 0;
            wready  = wvalid && (w_wait >= cfg.w_dly);
            w_wait  = wvalid ? w_wait + 1 : 0;
            rvalid  = rd_pend;
            rdata   = rd_val;
        end
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic void exp_write(input int k, output logic [AW-1:0] a, output logic [DW-1:0] d);
        if (k == 0) begin
            a = 12'h010; d = 32'd600;
        end else if (k <= NT) begin
            a = AW'(32 + 4 * (k - 1)); d = taps[k-1];
        end else begin
            a = 12'h000; d = 32'h1;
        end
    endfunction

    task automatic mark_bases();
        wr_base    = wr_addr_log.size();
        rd_base    = rd_log.size();
        poll_base  = poll_times.size();
        done_base  = done_cnt;
        proto_base = proto_err;
    endtask

    // go is pulsed a second time mid-run and the inputs are trashed: both must be ignored.
    task automatic launch(input string tag);
        len = 32'd600; coef = coef_vec; go = 1'b1;
        @(negedge clk);
        go = 1'b0; len = 32'hDEAD_BEEF; coef = ~coef_vec;
        chk({tag, "_busy_after_go"}, busy, 1);
        chk({tag, "_err_cleared"}, err, 0);
        repeat (20) @(negedge clk);
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int c = 0;
        while (busy && c < 4000) begin
            @(negedge clk);
            c++;
        end
        chk({tag, "_terminates"}, busy, 0);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        logic [AW-1:0] ea;
        logic [DW-1:0] ed;
        string         t;
        int            c;

        //            awd wd  cor dp  done err  code idx wr  rd  polls
        vecs[0] = '{0, 0, -1, 3,  1, 1'b0, 0, 0, 13, 14, 3};
        vecs[1] = '{0, 0,  5, 3,  0, 1'b1, 1, 5, 12,  6, 0};
        vecs[2] = '{0, 0, -1, 0,  0, 1'b1, 2, 0, 13, 19, 8};
        vecs[3] = '{3, 0, -1, 3,  1, 1'b0, 0, 0, 13, 14, 3};
        vecs[4] = '{0, 3, -1, 3,  1, 1'b0, 0, 0, 13, 14, 3};
        cfg = vecs[0];
        for (int i = 0; i < NT; i++) coef_vec[i*DW +: DW] = taps[i];

        repeat (3) @(negedge clk);
        chk("reset_outputs", outs, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int v = 0; v < 5; v++) begin
            t = $sformatf("v%0d", v);
            cfg = vecs[v];
            mark_bases();
            launch(t);
            wait_idle(t);
            chk({t, "_done_pulses"}, done_cnt - done_base, cfg.e_done);
            chk({t, "_err"}, err, cfg.e_err);
            chk({t, "_err_code"}, err_code, cfg.e_code);
            if (cfg.e_code == 1) chk({t, "_err_idx"}, err_idx, cfg.e_idx);
            chk({t, "_write_count"}, wr_addr_log.size() - wr_base, cfg.e_wr);
            chk({t, "_read_count"}, rd_log.size() - rd_base, cfg.e_rd);
            chk({t, "_poll_count"}, poll_times.size() - poll_base, cfg.e_polls);
            chk({t, "_protocol"}, proto_err - proto_base, 0);
            for (int k = wr_base; k < wr_addr_log.size(); k++) begin
                exp_write(k - wr_base, ea, ed);
                chk($sformatf("%s_wr%0d_addr", t, k - wr_base), wr_addr_log[k], ea);
                chk($sformatf("%s_wr%0d_data", t, k - wr_base), wr_data_log[k], ed);
            end
            for (int k = rd_base; k < rd_log.size(); k++) begin
                ea = (k - rd_base < NT) ? AW'(32 + 4 * (k - rd_base)) : 12'h000;
                chk($sformatf("%s_rd%0d_addr", t, k - rd_base), rd_log[k], ea);
            end
            for (int k = poll_base + 1; k < poll_times.size(); k++)
                chk($sformatf("%s_poll_gap%0d", t, k - poll_base), poll_times[k] - poll_times[k-1],
                    POLL_SPACING);
        end

        // reset asserted in the middle of a tap write
        cfg = vecs[0];
        mark_bases();
        launch("rst");
        c = 0;
        while (!(awvalid && awaddr >= 12'h024 && awaddr <= 12'h048) && c < 200) begin
            @(negedge clk);
            c++;
        end
        chk("rst_reached_wr_tap", awvalid, 1);
        #2 rst_n = 1'b0;
        #1 chk("rst_async_outputs", outs, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_no_done", done_cnt - done_base, 0);
        chk("rst_no_err", err, 0);
        mark_bases();
        launch("rst2");
        wait_idle("rst2");
        chk("rst2_first_write", (wr_addr_log.size() > wr_base) ? wr_addr_log[wr_base] : 12'hFFF, 12'h010);
        chk("rst2_write_count", wr_addr_log.size() - wr_base, 13);
        chk("rst2_done_pulses", done_cnt - done_base, 1);
        chk("rst2_err", err, 0);
        chk("rst2_protocol", proto_err - proto_base, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
